// File: rtl/complex_sq_scheduler.sv
// Four-channel round-robin scheduler in front of one shared, fixed-latency complex-square core.
// Each grant's channel tag rides a delay line so the core result lands in that channel's register.
module complex_sq_scheduler #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CORE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req_valid,
    output logic [3:0]           req_ready,
    input  logic [4*WIDTH-1:0]   req_real,
    input  logic [4*WIDTH-1:0]   req_imag,
    output logic                 core_valid,
    output logic [WIDTH-1:0]     core_real,
    output logic [WIDTH-1:0]     core_imag,
    input  logic [2*WIDTH-1:0]   core_out_real,
    input  logic [2*WIDTH-1:0]   core_out_imag,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [8*WIDTH-1:0]   out_real,
    output logic [8*WIDTH-1:0]   out_imag,
    output logic [2:0]           inflight
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } ch_state_e;

    ch_state_e          state_q [4];
    ch_state_e          state_d [4];
    logic [1:0]         ptr_q;
    logic [1:0]         ptr_d;
    logic [3:0]         eligible;
    logic               grant_any;
    logic [1:0]         grant_idx;
    logic [1:0]         scan_idx;
    logic [WIDTH-1:0]   grant_real;
    logic [WIDTH-1:0]   grant_imag;

    logic               core_valid_q;
    logic [WIDTH-1:0]   core_real_q;
    logic [WIDTH-1:0]   core_imag_q;
    logic [1:0]         core_tag_q;

    logic [CORE_LAT-1:0] line_valid_q;
    logic [1:0]          line_tag_q [CORE_LAT];
    logic                ret_valid;
    logic [1:0]          ret_tag;

    logic [2*WIDTH-1:0] res_real_q [4];
    logic [2*WIDTH-1:0] res_imag_q [4];
    logic [2:0]         inflight_q;
    logic [2:0]         inflight_d;

    // A channel still in DONE (even one being read now) is not IDLE, so it cannot be
    // re-granted until the cycle after the read; this also keeps req_ready off out_ready.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < 4; i++) begin
            eligible[i] = req_valid[i] && (state_q[i] == StIdle);
        end
    end

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!grant_any && eligible[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
        ptr_d = grant_any ? grant_idx + 2'd1 : ptr_q;
    end

    always_comb begin
        grant_real = '0;
        grant_imag = '0;
        for (int i = 0; i < 4; i++) begin
            if (grant_idx == 2'(i)) begin
                grant_real = req_real[i*WIDTH +: WIDTH];
                grant_imag = req_imag[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q        <= '0;
            core_valid_q <= 1'b0;
            core_real_q  <= '0;
            core_imag_q  <= '0;
            core_tag_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            core_valid_q <= grant_any;
            core_tag_q   <= grant_idx;
            if (grant_any) begin
                core_real_q <= grant_real;
                core_imag_q <= grant_imag;
            end
        end
    end

    // The line is fed from the core-input register, so its last stage is valid in
    // exactly the cycle the core presents that operand's result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_valid_q <= '0;
            for (int k = 0; k < CORE_LAT; k++) begin
                line_tag_q[k] <= '0;
            end
        end else begin
            line_valid_q[0] <= core_valid_q;
            line_tag_q[0]   <= core_tag_q;
            for (int k = 1; k < CORE_LAT; k++) begin
                line_valid_q[k] <= line_valid_q[k-1];
                line_tag_q[k]   <= line_tag_q[k-1];
            end
        end
    end

    assign ret_valid = line_valid_q[CORE_LAT-1];
    assign ret_tag   = line_tag_q[CORE_LAT-1];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                StIdle: if (grant_any && (grant_idx == 2'(i))) state_d[i] = StBusy;
                StBusy: if (ret_valid && (ret_tag == 2'(i)))   state_d[i] = StDone;
                StDone: if (out_ready[i])                       state_d[i] = StIdle;
                default: state_d[i] = StIdle;
            endcase
        end
    end

    always_comb begin
        inflight_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (state_d[i] == StBusy) begin
                inflight_d = inflight_d + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= StIdle;
            end
            inflight_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
            end
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                res_real_q[i] <= '0;
                res_imag_q[i] <= '0;
            end
        end else if (ret_valid && (state_q[ret_tag] == StBusy)) begin
            res_real_q[ret_tag] <= core_out_real;
            res_imag_q[ret_tag] <= core_out_imag;
        end
    end

    always_comb begin
        out_valid = '0;
        out_real  = '0;
        out_imag  = '0;
        for (int i = 0; i < 4; i++) begin
            out_valid[i]                      = (state_q[i] == StDone);
            out_real[i*2*WIDTH +: 2*WIDTH]    = res_real_q[i];
            out_imag[i*2*WIDTH +: 2*WIDTH]    = res_imag_q[i];
        end
    end

    assign core_valid = core_valid_q;
    assign core_real  = core_real_q;
    assign core_imag  = core_imag_q;
    assign inflight   = inflight_q;

endmodule

// File: tb/tb_complex_sq_scheduler.sv
// Directed bench for complex_sq_scheduler with a two-stage registered complex-square core model.
module tb_complex_sq_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_real;
    logic [31:0] req_imag;
    logic        core_valid;
    logic [7:0]  core_real;
    logic [7:0]  core_imag;
    logic [15:0] core_out_real;
    logic [15:0] core_out_imag;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [63:0] out_real;
    logic [63:0] out_imag;
    logic [2:0]  inflight;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    complex_sq_scheduler #(.WIDTH(8), .CORE_LAT(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_real      (req_real),
        .req_imag      (req_imag),
        .core_valid    (core_valid),
        .core_real     (core_real),
        .core_imag     (core_imag),
        .core_out_real (core_out_real),
        .core_out_imag (core_out_imag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_real      (out_real),
        .out_imag      (out_imag),
        .inflight      (inflight)
    );

    function automatic logic [15:0] sq_re(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        sa = 16'($signed(a));
        sb = 16'($signed(b));
        return 16'(sa * sa - sb * sb);
    endfunction

    function automatic logic [15:0] sq_im(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        sa = 16'($signed(a));
        sb = 16'($signed(b));
        return 16'(16'sd2 * sa * sb);
    endfunction

    // Core model: result appears two cycles after the operand is presented; not reset.
    logic [15:0] p1_re, p1_im, p2_re, p2_im;
    always @(posedge clk) begin
        p1_re <= sq_re(core_real, core_imag);
        p1_im <= sq_im(core_real, core_imag);
        p2_re <= p1_re;
        p2_im <= p1_im;
    end
    assign core_out_real = p2_re;
    assign core_out_imag = p2_im;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int ch, input logic [7:0] re, input logic [7:0] im);
        req_real[ch*8 +: 8] = re;
        req_imag[ch*8 +: 8] = im;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic int oh2i(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    logic [7:0]  op_re  [4] = '{8'd1, 8'd2, 8'd5, 8'h80};
    logic [7:0]  op_im  [4] = '{8'd1, 8'hFD, 8'd0, 8'd127};
    logic [15:0] exp_re [4] = '{16'h0000, 16'hFFFB, 16'h0019, 16'h00FF};
    logic [15:0] exp_im [4] = '{16'h0002, 16'hFFF4, 16'h0000, 16'h8100};
    logic [3:0]  t2_rdy [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic        t2_cv  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0]  t2_ov  [9] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'h0};
    logic [2:0]  t2_inf [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    int grants[$];

    initial begin
        req_real = '0;
        req_imag = '0;

        // Reset state and a single request on channel 0
        do_reset();
        #1;
        chk("rst_core_valid", core_valid, 0);
        chk("rst_core_real", core_real, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_real", out_real, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_req_ready", req_ready, 0);
        tick();
        set_op(0, 8'd3, 8'd4);
        req_valid = 4'b0001;
        #1;
        chk("t1_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        #1;
        chk("t1_core_valid", core_valid, 1);
        chk("t1_core_real", core_real, 8'd3);
        chk("t1_core_imag", core_imag, 8'd4);
        chk("t1_inflight1", inflight, 3'd1);
        tick();
        #1;
        chk("t1_core_valid_off", core_valid, 0);
        tick();
        #1;
        chk("t1_out_valid_c3", out_valid, 0);
        tick();
        out_ready = 4'b0001;
        #1;
        chk("t1_out_valid_c4", out_valid, 4'b0001);
        chk("t1_out_real", out_real[15:0], 16'hFFF9);
        chk("t1_out_imag", out_imag[15:0], 16'h0018);
        tick();
        out_ready = '0;
        #1;
        chk("t1_out_valid_read", out_valid, 0);
        chk("t1_inflight0", inflight, 0);

        // All four channels at once from ptr=0
        do_reset();
        for (int c = 0; c < 9; c++) begin
            tick();
            if (c == 0) begin
                for (int i = 0; i < 4; i++) set_op(i, op_re[i], op_im[i]);
            end
            req_valid = (c < 4) ? 4'hF : 4'h0;
            out_ready = (c == 7) ? 4'hF : 4'h0;
            #1;
            chk($sformatf("t2_ready_c%0d", c), req_ready, t2_rdy[c]);
            chk($sformatf("t2_core_valid_c%0d", c), core_valid, t2_cv[c]);
            chk($sformatf("t2_out_valid_c%0d", c), out_valid, t2_ov[c]);
            chk($sformatf("t2_inflight_c%0d", c), inflight, t2_inf[c]);
            if (c >= 1 && c <= 4) begin
                chk($sformatf("t2_core_real_c%0d", c), core_real, op_re[c-1]);
                chk($sformatf("t2_core_imag_c%0d", c), core_imag, op_im[c-1]);
            end
            if (c == 7) begin
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("t2_res_re_ch%0d", i), out_real[i*16 +: 16], exp_re[i]);
                    chk($sformatf("t2_res_im_ch%0d", i), out_imag[i*16 +: 16], exp_im[i]);
                end
            end
        end

        // Fairness: ch1 and ch3 continuously requesting, results read at once
        do_reset();
        tick();
        set_op(1, 8'd3, 8'd4);
        set_op(3, 8'd0, 8'd1);
        req_valid = 4'b1010;
        out_ready = 4'hF;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) tick();
            #1;
            if (req_ready != 4'h0) begin
                chk("t3_onehot", 64'($onehot(req_ready)), 1);
                grants.push_back(oh2i(req_ready));
            end
            if (out_valid[1]) begin
                chk("t3_ch1_re", out_real[31:16], 16'hFFF9);
                chk("t3_ch1_im", out_imag[31:16], 16'h0018);
            end
            if (out_valid[3]) begin
                chk("t3_ch3_re", out_real[63:48], 16'hFFFF);
                chk("t3_ch3_im", out_imag[63:48], 16'h0000);
            end
        end
        chk("t3_ngrants", 64'(grants.size()), 8);
        for (int k = 0; k < grants.size(); k++) begin
            chk($sformatf("t3_grant%0d", k), 64'(grants[k]), (k % 2 == 1) ? 3 : 1);
        end
        req_valid = '0;
        repeat (8) tick();
        #1;
        chk("t3_drain_inflight", inflight, 0);
        chk("t3_drain_out_valid", out_valid, 0);

        // Backpressure on ch0, then same-cycle read and request
        do_reset();
        tick();
        set_op(0, 8'd2, 8'd2);
        req_valid = 4'b0001;
        out_ready = '0;
        #1;
        chk("t4_grant0", req_ready, 4'b0001);
        for (int c = 1; c < 4; c++) begin
            tick();
            #1;
            chk($sformatf("t4_busy_noready_c%0d", c), req_ready, 0);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 0) begin
                set_op(2, 8'd1, 8'd2);
                req_valid = 4'b0101;
                out_ready = 4'b0100;
            end
            if (k == 1) req_valid = 4'b0001;
            #1;
            chk($sformatf("t4_hold_valid_k%0d", k), out_valid[0], 1);
            chk($sformatf("t4_hold_re_k%0d", k), out_real[15:0], 16'h0000);
            chk($sformatf("t4_hold_im_k%0d", k), out_imag[15:0], 16'h0008);
            chk($sformatf("t4_no_regrant_k%0d", k), req_ready[0], 0);
            if (k == 0) chk("t4_ch2_grant", req_ready, 4'b0100);
            if (k == 4) begin
                chk("t4_ch2_done", out_valid, 4'b0101);
                chk("t4_ch2_re", out_real[47:32], 16'hFFFD);
                chk("t4_ch2_im", out_imag[47:32], 16'h0004);
            end
            if (k == 5) chk("t4_ch2_read", out_valid, 4'b0001);
        end
        tick();
        out_ready = 4'b0001;
        set_op(0, 8'hFD, 8'd1);
        #1;
        chk("t6_read_cycle_valid", out_valid, 4'b0001);
        chk("t6_read_cycle_noready", req_ready, 0);
        tick();
        out_ready = '0;
        #1;
        chk("t6_next_valid", out_valid, 0);
        chk("t6_next_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        #1;
        chk("t6_core_valid", core_valid, 1);
        chk("t6_core_real", core_real, 8'hFD);
        tick();
        tick();
        #1;
        chk("t6_not_yet", out_valid, 0);
        tick();
        #1;
        chk("t6_done", out_valid, 4'b0001);
        chk("t6_re", out_real[15:0], 16'h0008);
        chk("t6_im", out_imag[15:0], 16'hFFFA);
        out_ready = 4'b0001;
        tick();
        out_ready = '0;
        #1;
        chk("t6_read", out_valid, 0);

        // Reset while ch2's operation is in flight
        do_reset();
        tick();
        set_op(2, 8'd6, 8'd1);
        req_valid = 4'b0100;
        #1;
        chk("t5_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("t5_core_valid", core_valid, 1);
        tick();
        rst = 1'b0;
        #1;
        chk("t5_rst_core_valid", core_valid, 0);
        chk("t5_rst_core_real", core_real, 0);
        chk("t5_rst_inflight", inflight, 0);
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_out_real", out_real, 0);
        tick();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            chk($sformatf("t5_stale_ignored_k%0d", k), out_valid, 0);
            chk($sformatf("t5_stale_inflight_k%0d", k), inflight, 0);
        end
        tick();
        set_op(2, 8'd7, 8'd0);
        req_valid = 4'b0100;
        #1;
        chk("t5_new_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        repeat (3) tick();
        #1;
        chk("t5_new_done", out_valid, 4'b0100);
        chk("t5_new_re", out_real[47:32], 16'h0031);
        chk("t5_new_im", out_imag[47:32], 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
